// File: rtl/exu_bp_update_queue_if.sv
// Branch-resolution push side and IFU predictor-update side of the update queue.
// The master modport is the queue itself; the slave modport is its environment.
interface exu_bp_update_queue_if #(
  parameter int IDX_W = 8
);
  logic             in_valid;
  logic             in_kill;
  logic [30:0]      in_pc;
  logic             in_misp;
  logic             in_ataken;
  logic [1:0]       in_hist;
  logic             in_way;
  logic [IDX_W-1:0] in_index;

  logic             upd_valid;
  logic             upd_ready;
  logic [30:0]      upd_pc;
  logic             upd_misp;
  logic             upd_ataken;
  logic [1:0]       upd_hist;
  logic             upd_way;
  logic [IDX_W-1:0] upd_index;

  modport master (
    input  in_valid, in_kill, in_pc, in_misp, in_ataken, in_hist, in_way, in_index,
    input  upd_ready,
    output upd_valid, upd_pc, upd_misp, upd_ataken, upd_hist, upd_way, upd_index
  );

  modport slave (
    output in_valid, in_kill, in_pc, in_misp, in_ataken, in_hist, in_way, in_index,
    output upd_ready,
    input  upd_valid, upd_pc, upd_misp, upd_ataken, upd_hist, upd_way, upd_index
  );
endinterface

// File: rtl/exu_bp_update_queue.sv
// Circular queue decoupling resolved-branch predictor updates from IFU back-pressure,
// with saturating overflow-drop and delivered-mispredict statistics.
module exu_bp_update_queue #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     freeze,
  exu_bp_update_queue_if.master    bus,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     q_full,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [CNT_W-1:0]         misp_cnt
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [30:0]      pc;
    logic             misp;
    logic             ataken;
    logic [1:0]       hist;
    logic             way;
    logic [IDX_W-1:0] index;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           in_entry;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             push;
  logic             pop;
  logic             accept;
  logic             drop;

  assign full   = (count == FULL_CNT);
  assign push   = bus.in_valid & ~bus.in_kill & ~freeze;
  assign pop    = bus.upd_valid & bus.upd_ready;
  // A full queue still accepts when the head leaves in the same cycle.
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  assign in_entry = '{pc: bus.in_pc, misp: bus.in_misp, ataken: bus.in_ataken,
                      hist: bus.in_hist, way: bus.in_way, index: bus.in_index};
  assign head     = mem[rd_ptr];

  // NOTE: every clocked assignment is non-blocking so all flops update from
  // the same pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
      misp_cnt <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (drop && !(&drop_cnt))             drop_cnt <= drop_cnt + 1'b1;
      if (pop && head.misp && !(&misp_cnt)) misp_cnt <= misp_cnt + 1'b1;
    end
  end

  // NOTE: entry storage has no reset; valid-ness lives entirely in count, so
  // stale payload is never observable and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (rst_l && accept) mem[wr_ptr] <= in_entry;
  end

  assign bus.upd_valid  = (count != '0);
  assign bus.upd_pc     = head.pc;
  assign bus.upd_misp   = head.misp;
  assign bus.upd_ataken = head.ataken;
  assign bus.upd_hist   = head.hist;
  assign bus.upd_way    = head.way;
  assign bus.upd_index  = head.index;

  assign q_count = count;
  assign q_full  = full;

endmodule

// File: tb/tb_exu_bp_update_queue.sv
// Randomized and directed bench for exu_bp_update_queue against a queue-based
// reference model; small statistics width exercises counter saturation.
module tb_exu_bp_update_queue;

  localparam int DEPTH = 4;
  localparam int IDX_W = 8;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [30:0]      pc;
    logic             misp;
    logic             ataken;
    logic [1:0]       hist;
    logic             way;
    logic [IDX_W-1:0] index;
  } ent_t;

  logic                   clk;
  logic                   rst_l;
  logic                   freeze;
  logic [$clog2(DEPTH):0] q_count;
  logic                   q_full;
  logic [CNT_W-1:0]       drop_cnt;
  logic [CNT_W-1:0]       misp_cnt;

  exu_bp_update_queue_if #(.IDX_W(IDX_W)) bus ();

  exu_bp_update_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_l    (rst_l),
    .freeze   (freeze),
    .bus      (bus),
    .q_count  (q_count),
    .q_full   (q_full),
    .drop_cnt (drop_cnt),
    .misp_cnt (misp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  ent_t mq[$];
  int   m_drop = 0;
  int   m_misp = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ent_t cur_in();
    return '{pc: bus.in_pc, misp: bus.in_misp, ataken: bus.in_ataken,
             hist: bus.in_hist, way: bus.in_way, index: bus.in_index};
  endfunction

  function automatic ent_t cur_head();
    return '{pc: bus.upd_pc, misp: bus.upd_misp, ataken: bus.upd_ataken,
             hist: bus.upd_hist, way: bus.upd_way, index: bus.upd_index};
  endfunction

  // Inputs change only at the falling edge, with fresh random payload.
  task automatic drive(bit v, bit k, bit f, bit r);
    bus.in_valid  = v;
    bus.in_kill   = k;
    freeze        = f;
    bus.upd_ready = r;
    bus.in_pc     = 31'($urandom);
    bus.in_misp   = 1'($urandom);
    bus.in_ataken = 1'($urandom);
    bus.in_hist   = 2'($urandom);
    bus.in_way    = 1'($urandom);
    bus.in_index  = IDX_W'($urandom);
  endtask

  // Advance the model by one clock from the driven inputs, then compare.
  task automatic step();
    bit   mpush;
    bit   mpop;
    bit   mfull;
    ent_t e;
    if (!rst_l) begin
      mq.delete();
      m_drop = 0;
      m_misp = 0;
    end else begin
      mpush = bus.in_valid && !bus.in_kill && !freeze;
      mpop  = (mq.size() > 0) && bus.upd_ready;
      mfull = (mq.size() == DEPTH);
      e     = cur_in();
      if (mpop) begin
        if (mq[0].misp && m_misp < CMAX) m_misp++;
        void'(mq.pop_front());
      end
      if (mpush) begin
        if (!mfull || mpop) mq.push_back(e);
        else if (m_drop < CMAX) m_drop++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("upd_valid", 64'(bus.upd_valid), 64'(mq.size() > 0));
    check("q_count",   64'(q_count),       64'(mq.size()));
    check("q_full",    64'(q_full),        64'(mq.size() == DEPTH));
    check("drop_cnt",  64'(drop_cnt),      64'(m_drop));
    check("misp_cnt",  64'(misp_cnt),      64'(m_misp));
    if (mq.size() > 0) check("head", 64'(cur_head()), 64'(mq[0]));
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    drive(0, 0, 0, 0);
    step();
    rst_l = 1'b1;
  endtask

  initial begin
    ent_t late;
    rst_l = 1'b0;
    drive(0, 0, 0, 0);
    step();
    step();
    rst_l = 1'b1;

    // Single entry, held under back-pressure, then popped.
    drive(1, 0, 0, 0);
    bus.in_pc   = 31'h2000_0080;
    bus.in_misp = 1'b1;
    step();
    check("t1_pc", 64'(bus.upd_pc), 64'h2000_0080);
    drive(0, 0, 0, 0);
    repeat (5) step();
    drive(0, 0, 0, 1);
    step();
    check("t1_misp_cnt", 64'(misp_cnt), 64'd1);
    check("t1_empty", 64'(bus.upd_valid), 64'd0);

    // Overflow: six pushes into four slots, then ordered drain.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 0);
      step();
      if (i == 3) check("t2_full_at4", 64'(q_full), 64'd1);
    end
    check("t2_drop", 64'(drop_cnt), 64'd2);
    drive(0, 0, 0, 1);
    repeat (4) step();
    check("t2_drained", 64'(q_count), 64'd0);

    // Push and pop together while full; new entry comes out fourth.
    do_reset();
    repeat (4) begin
      drive(1, 0, 0, 0);
      step();
    end
    drive(1, 0, 0, 1);
    late = cur_in();
    step();
    check("t3_count", 64'(q_count), 64'd4);
    check("t3_drop", 64'(drop_cnt), 64'd0);
    drive(0, 0, 0, 1);
    repeat (3) step();
    check("t3_late_4th", 64'(cur_head()), 64'(late));
    step();

    // Kill and freeze block pushes; freeze does not block pops.
    do_reset();
    drive(1, 1, 0, 0);
    step();
    drive(1, 0, 1, 0);
    step();
    check("t4_no_push", 64'(q_count), 64'd0);
    drive(1, 0, 0, 0);
    step();
    drive(0, 0, 1, 1);
    step();
    check("t4_frz_pop", 64'(q_count), 64'd0);

    // Streaming with alternating ready.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      drive(1, 0, 0, i[0]);
      step();
    end
    drive(0, 0, 0, 1);
    repeat (DEPTH + 1) step();

    // Drop counter saturation, then reset mid-stream.
    do_reset();
    for (int i = 0; i < DEPTH + 17; i++) begin
      drive(1, 0, 0, 0);
      step();
    end
    check("t6_drop_sat", 64'(drop_cnt), 64'(CMAX));
    rst_l = 1'b0;
    drive(1, 0, 0, 1);
    step();
    check("t6_rst_valid", 64'(bus.upd_valid), 64'd0);
    check("t6_rst_drop", 64'(drop_cnt), 64'd0);
    check("t6_rst_misp", 64'(misp_cnt), 64'd0);
    rst_l = 1'b1;

    // Fully random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) == 0), 1'($urandom));
      rst_l = ($urandom_range(0, 99) != 0);
      step();
    end
    rst_l = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exu_bp_update_queue.md
# exu_bp_update_queue

Buffers branch-resolution results leaving the ALU stage (the resolved predict packet: misprediction, actual direction, new 2-bit history, way and index) and drains them to the IFU branch-predictor update port over a valid/ready handshake. It sits directly downstream of the ALU branch logic, decoupling predictor updates from IFU back-pressure so the execute pipe never stalls on them. It also keeps saturating drop and update statistics counters for the predictor-accuracy runs.

## Interface
Parameters:
- DEPTH, 4, number of queue entries; power of two, 2..16
- IDX_W, 8, predictor index width
- CNT_W, 16, statistics counter width

Ports:
- clk  in  1  top-level clock
- rst_l  in  1  reset; one clock; reset is synchronous and active-low
- freeze  in  1  pipe freeze; blocks pushes
- in_valid  in  1  resolved branch present (ALU valid & branch/jal predecode)
- in_kill  in  1  same-cycle pipeline flush; cancels the push
- in_pc  in  31  branch PC [31:1]
- in_misp  in  1  branch mispredicted
- in_ataken  in  1  actual direction
- in_hist  in  2  new 2-bit history
- in_way  in  1  BTB way
- in_index  in  IDX_W  predictor index
- upd_valid  out  1  head entry valid
- upd_ready  in  1  IFU accepts the head this cycle
- upd_pc, upd_misp, upd_ataken, upd_hist, upd_way, upd_index  out  as inputs  head entry fields
- q_count  out  log2(DEPTH)+1  occupancy
- q_full  out  1  q_count == DEPTH
- drop_cnt  out  CNT_W  pushes lost to overflow, saturating
- misp_cnt  out  CNT_W  mispredict entries delivered, saturating

## Operation
- push = in_valid & ~in_kill & ~freeze
- pop = upd_valid & upd_ready
- Circular buffer with write pointer, read pointer and count. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Push is accepted when count < DEPTH, or when count == DEPTH and pop is high in the same cycle (simultaneous push+pop while full succeeds).
- Push while full with no pop: entry discarded, drop_cnt += 1 (saturates at all-ones), state otherwise unchanged.
- Push+pop in the same cycle: count unchanged, both pointers advance.
- Pop with nothing valid is impossible by construction. upd_ready is ignored when upd_valid = 0.
- misp_cnt += 1 on every pop whose head has upd_misp = 1 (saturating).
- upd_* fields are driven directly from the head entry. They are don't-care when upd_valid = 0; the bench does not check them then.
- Entries are delivered strictly in push order. No coalescing, no reordering.
- freeze does not block pops. in_kill does not remove entries already queued.

## Timing
- Reset (rst_l = 0 at a clk edge): pointers = 0, count = 0, upd_valid = 0, q_full = 0, drop_cnt = 0, misp_cnt = 0. Entry storage is not reset.
- Reset asserted mid-operation discards all queued entries at that edge, with no deliveries that cycle.
- Latency: push accepted at edge N gives upd_valid = 1 and fields visible after edge N (cycle N+1). There is no same-cycle bypass when empty.
- upd_valid, q_count and q_full are registered (derived from count flops), not combinational from in_valid.
- Handshake: the head is held stable while upd_valid & ~upd_ready. The next entry appears the cycle after a pop.
- Sustained throughput is one push and one pop per cycle.

## Test plan
- Reset, then push 1 entry (pc = 0x4000_0100>>1, misp = 1) with upd_ready = 0 -> next cycle upd_valid = 1 with matching fields, held for 5 cycles. Raise upd_ready -> pop, misp_cnt = 1, upd_valid = 0 the next cycle.
- upd_ready = 0, push 6 entries with DEPTH = 4 -> q_full = 1 after 4 pushes, drop_cnt = 2, then drain 4 entries in push order.
- Full queue, push+pop in the same cycle -> count stays 4, the new entry is delivered 4th, drop_cnt unchanged.
- in_valid = 1 with in_kill = 1, then with freeze = 1 -> no push, count = 0. With freeze = 1 and upd_ready = 1 on a non-empty queue -> the pop still occurs.
- Streaming 40 pushes with upd_ready toggling 1/0 -> pointer wrap is exercised, every accepted entry is delivered exactly once in order, and count never exceeds DEPTH.
- Force drop_cnt near saturation (CNT_W = 4, 17 overflow pushes) -> drop_cnt = 15. Assert rst_l = 0 mid-stream -> all counters and upd_valid are 0 the next cycle.
